wb_regfile: RTL and testbench

Writeback-side register file for the 19-bit processor. It accepts the registered ALU result and destination index that the execute stage produces, and commits them into an 8-entry × 19-bit architectural register file. It also serves the two operand reads for the next issue, with same-cycle write-to-read bypass, and keeps a per-register pending-write scoreboard so issue logic can detect RAW hazards.

---
 rtl/proc19_pkg.sv | 11 +
 rtl/wb_scoreboard.sv | 65 ++++++
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/proc19_pkg.sv
// Shared types and sizes for the 19-bit processor datapath.
package proc19_pkg;
  localparam int DATA_W   = 19;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters for RAW hazard detection.
// R0 never has a producer, so its counter is pinned at zero.
module wb_scoreboard
  import proc19_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     wb_valid,
  input  reg_idx_t wb_rd,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  reg_idx_t rs1_addr,
  input  reg_idx_t rs2_addr,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     issue_ready,
  output logic     err_underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_REGS-1:0][CNT_W-1:0] pend;
  logic [NUM_REGS-1:0]            inc, dec;
  logic                           wb_hit, iss_acc;

  assign wb_hit      = wb_valid && (wb_rd != REG_ZERO);
  assign issue_ready = (issue_rd == REG_ZERO) || (pend[issue_rd] != CNT_MAX);
  assign iss_acc     = issue_valid && issue_ready && (issue_rd != REG_ZERO);

  // A writeback that retires the last producer satisfies the read via bypass.
  assign rs1_busy = (pend[rs1_addr] != '0) &&
                    !((pend[rs1_addr] == CNT_ONE) && wb_hit && (wb_rd == rs1_addr));
  assign rs2_busy = (pend[rs2_addr] != '0) &&
                    !((pend[rs2_addr] == CNT_ONE) && wb_hit && (wb_rd == rs2_addr));

  // Decode per-register increment / decrement requests.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = iss_acc && (issue_rd == reg_idx_t'(r));
      dec[r] = wb_hit && (wb_rd == reg_idx_t'(r)) && (pend[r] != '0);
    end
  end

  // Pending counters; simultaneous issue and retire on one register cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r])      pend[r] <= pend[r] + CNT_ONE;
        else if (dec[r] && !inc[r]) pend[r] <= pend[r] - CNT_ONE;
      end
    end
  end

  // Sticky flag: a writeback arrived with no outstanding producer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              err_underflow <= 1'b0;
    else if (wb_hit && (pend[wb_rd] == '0))    err_underflow <= 1'b1;
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback register file: 8 x 19-bit, R0 hardwired zero, two bypassed
// read ports, commit counter and pending-write scoreboard.
module wb_regfile
  import proc19_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid_in,
  input  logic [ADDR_W-1:0] wb_rd_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic [15:0]       wb_count,
  output logic              err_underflow
);
  word_t regs [NUM_REGS];
  logic  wb_hit;

  assign wb_hit = wb_valid_in && (wb_rd_in != REG_ZERO);

  // Architectural state; regs[0] is reset and never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wb_hit) begin
      for (int r = 1; r < NUM_REGS; r++)
        if (wb_rd_in == reg_idx_t'(r)) regs[r] <= wb_data_in;
    end
  end

  // Count committed non-R0 writebacks, wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    wb_count <= '0;
    else if (wb_hit) wb_count <= wb_count + 16'd1;
  end

  // Same-cycle write-to-read bypass on both ports.
  assign rs1_data = (wb_hit && (rs1_addr == wb_rd_in)) ? wb_data_in : regs[rs1_addr];
  assign rs2_data = (wb_hit && (rs2_addr == wb_rd_in)) ? wb_data_in : regs[rs2_addr];

  wb_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_valid     (wb_valid_in),
    .wb_rd        (wb_rd_in),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .issue_ready  (issue_ready),
    .err_underflow(err_underflow)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: inputs change on the falling edge,
// outputs are sampled 1ns later, state updates on the rising edge.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid_in;
  logic [2:0]  wb_rd_in;
  logic [18:0] wb_data_in;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [18:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic        issue_ready;
  logic [15:0] wb_count;
  logic        err_underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid_in(wb_valid_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_count(wb_count), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then drive idle inputs.
  task automatic step_idle();
    @(negedge clk);
    wb_valid_in = 1'b0; wb_rd_in = '0; wb_data_in = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    wb_valid_in = 1'b0; wb_rd_in = '0; wb_data_in = '0;
    rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Reset state
    for (int r = 1; r < 8; r++) begin
      rs1_addr = 3'(r); rs2_addr = 3'(r); issue_rd = 3'(r);
      #1;
      chk($sformatf("rst_rs1_data_r%0d", r), 32'(rs1_data), 32'h0);
      chk($sformatf("rst_rs2_busy_r%0d", r), 32'(rs2_busy), 32'h0);
      chk($sformatf("rst_ready_r%0d", r),    32'(issue_ready), 32'h1);
    end
    chk("rst_wb_count", 32'(wb_count), 32'h0);
    chk("rst_err", 32'(err_underflow), 32'h0);

    // Commit to R3 with same-cycle bypass (no producer -> underflow)
    step_idle();
    wb_valid_in = 1'b1; wb_rd_in = 3'd3; wb_data_in = 19'h4_ABCD;
    rs1_addr = 3'd3; rs2_addr = 3'd1;
    #1;
    chk("bypass_rs1", 32'(rs1_data), 32'h4ABCD);
    chk("nobypass_rs2", 32'(rs2_data), 32'h0);
    step_idle();
    #1;
    chk("commit_rs1", 32'(rs1_data), 32'h4ABCD);
    chk("commit_count", 32'(wb_count), 32'd1);
    chk("commit_underflow", 32'(err_underflow), 32'h1);

    // R0 discard
    wb_valid_in = 1'b1; wb_rd_in = 3'd0; wb_data_in = 19'h7_FFFF;
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    #1;
    chk("r0_nobypass_rs2", 32'(rs2_data), 32'h0);
    step_idle();
    #1;
    chk("r0_read", 32'(rs1_data), 32'h0);
    chk("r0_count", 32'(wb_count), 32'd1);

    // Saturate R5 with three issues
    rs1_addr = 3'd5;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 3'd5;
      #1;
      chk($sformatf("sat_ready_pre%0d", i), 32'(issue_ready), 32'h1);
      step_idle();
    end
    issue_rd = 3'd5;
    #1;
    chk("sat_busy", 32'(rs1_busy), 32'h1);
    chk("sat_ready", 32'(issue_ready), 32'h0);
    // Fourth issue is refused
    issue_valid = 1'b1; issue_rd = 3'd5;
    step_idle();
    issue_rd = 3'd5;
    #1;
    chk("sat_4th_ignored", 32'(issue_ready), 32'h0);
    // Drain with three writebacks
    wb_valid_in = 1'b1; wb_rd_in = 3'd5; wb_data_in = 19'h0_0100;
    #1;
    chk("drain1_busy", 32'(rs1_busy), 32'h1);
    step_idle();
    wb_valid_in = 1'b1; wb_rd_in = 3'd5; wb_data_in = 19'h0_0200;
    #1;
    chk("drain2_busy", 32'(rs1_busy), 32'h1);
    step_idle();
    wb_valid_in = 1'b1; wb_rd_in = 3'd5; wb_data_in = 19'h0_0300;
    #1;
    chk("drain3_busy_bypass", 32'(rs1_busy), 32'h0);
    chk("drain3_data", 32'(rs1_data), 32'h300);
    step_idle();
    issue_rd = 3'd5;
    #1;
    chk("drain_done_busy", 32'(rs1_busy), 32'h0);
    chk("drain_done_data", 32'(rs1_data), 32'h300);
    chk("drain_done_ready", 32'(issue_ready), 32'h1);
    chk("drain_done_count", 32'(wb_count), 32'd4);

    // R2: issue, then issue + writeback together
    issue_valid = 1'b1; issue_rd = 3'd2;
    step_idle();
    issue_valid = 1'b1; issue_rd = 3'd2;
    wb_valid_in = 1'b1; wb_rd_in = 3'd2; wb_data_in = 19'h0_0055;
    rs2_addr = 3'd2;
    #1;
    chk("r2_same_busy", 32'(rs2_busy), 32'h0);
    step_idle();
    #1;
    chk("r2_next_busy", 32'(rs2_busy), 32'h1);
    chk("r2_next_data", 32'(rs2_data), 32'h55);
    chk("r2_count", 32'(wb_count), 32'd5);

    // Issue R4, reset mid-run, then an orphan writeback
    issue_valid = 1'b1; issue_rd = 3'd4; rs1_addr = 3'd4;
    step_idle();
    #1;
    chk("r4_busy", 32'(rs1_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(rs1_busy), 32'h0);
    chk("midrst_r2_data", 32'(rs2_data), 32'h0);
    chk("midrst_count", 32'(wb_count), 32'h0);
    chk("midrst_err", 32'(err_underflow), 32'h0);
    step_idle();
    reset_n = 1'b1;
    step_idle();
    wb_valid_in = 1'b1; wb_rd_in = 3'd4; wb_data_in = 19'h0_1234;
    #1;
    chk("orphan_busy", 32'(rs1_busy), 32'h0);
    chk("orphan_bypass", 32'(rs1_data), 32'h1234);
    step_idle();
    #1;
    chk("orphan_err", 32'(err_underflow), 32'h1);
    chk("orphan_data", 32'(rs1_data), 32'h1234);
    chk("orphan_count", 32'(wb_count), 32'd1);
    step_idle();
    #1;
    chk("orphan_err_sticky", 32'(err_underflow), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
